// File: rtl/m68k_bus_dma_if.sv
// rtl/m68k_bus_dma_if.sv - 68000-style bus initiator signal bundle
//
// Groups the arbitration pins (br_n/bg_n/bgack_n), the address/data
// strobes and the data paths of one 68000-style bus port.
//   master : the DMA engine (drives address, strobes, write data, request)
//   slave  : the arbiter/responder glue (drives grant, read data, dtack_n)
interface m68k_bus_dma_if;
  logic        br_n;
  logic        bg_n;
  logic        bgack_n;
  logic [22:0] eab;
  logic        as_n;
  logic        uds_n;
  logic        lds_n;
  logic        rw;
  logic [15:0] dout;
  logic [15:0] din;
  logic        dtack_n;

  modport master (
    output br_n, bgack_n, eab, as_n, uds_n, lds_n, rw, dout,
    input  bg_n, din, dtack_n
  );

  modport slave (
    input  br_n, bgack_n, eab, as_n, uds_n, lds_n, rw, dout,
    output bg_n, din, dtack_n
  );
endinterface

// File: rtl/m68k_bus_dma.sv
// rtl/m68k_bus_dma.sv - word copy/fill DMA engine acting as a 68000-style bus initiator
//
// Takes the shared bus through BR/BG/BGACK, then moves word_count 16-bit
// words from src to dst (or writes fill_data to dst) using AS/UDS/LDS/DTACK
// bus cycles. A bus cycle that waits TIMEOUT cycles for DTACK aborts the
// command with a sticky error.
//   clk, reset        : clock, synchronous active-high reset
//   start_i           : command strobe, only sampled while idle
//   src_addr_i        : source word address
//   dst_addr_i        : destination word address
//   word_count_i      : words to move, 0 = complete immediately
//   fill_mode_i       : 1 = write fill_data_i only, no reads
//   fill_data_i       : fill value
//   busy_o            : command in progress
//   done_o            : one-cycle pulse at the end of each command
//   error_o           : sticky DTACK timeout flag
//   words_done_o      : completed writes of the current command
//   bus               : master side of the 68000-style bus
module m68k_bus_dma #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [22:0]           src_addr_i,
  input  logic [22:0]           dst_addr_i,
  input  logic [15:0]           word_count_i,
  input  logic                  fill_mode_i,
  input  logic [15:0]           fill_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [15:0]           words_done_o,
  m68k_bus_dma_if.master        bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_OWN, S_RD_ADDR, S_RD_STB, S_RD_END,
    S_WR_ADDR, S_WR_STB, S_WR_END, S_RELEASE
  } state_t;

  // The stall counter is cleared as the strobes fall and the abort happens
  // on the TIMEOUT-th stalled strobe cycle, so compare against TIMEOUT-1.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [22:0] src_q;
  logic [22:0] dst_q;
  logic [15:0] remain_q;
  logic        fill_mode_q;
  logic [15:0] fill_data_q;
  logic [15:0] data_q;
  logic [15:0] tmo_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [15:0] words_done_q;
  logic        br_n_q;
  logic        bgack_n_q;
  logic [22:0] eab_q;
  logic        strb_n_q;
  logic        rw_q;
  logic [15:0] dout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      remain_q     <= '0;
      fill_mode_q  <= 1'b0;
      fill_data_q  <= '0;
      data_q       <= '0;
      tmo_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      words_done_q <= '0;
      br_n_q       <= 1'b1;
      bgack_n_q    <= 1'b1;
      eab_q        <= '0;
      strb_n_q     <= 1'b1;
      rw_q         <= 1'b1;
      dout_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            error_q      <= 1'b0;
            words_done_q <= '0;
            if (word_count_i == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              src_q       <= src_addr_i;
              dst_q       <= dst_addr_i;
              remain_q    <= word_count_i;
              fill_mode_q <= fill_mode_i;
              fill_data_q <= fill_data_i;
              busy_q      <= 1'b1;
              br_n_q      <= 1'b0;
              state_q     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // Wait for the previous owner's DTACK to clear before taking the bus.
          if (!bus.bg_n && bus.dtack_n) begin
            br_n_q    <= 1'b1;
            bgack_n_q <= 1'b0;
            state_q   <= S_OWN;
          end
        end
        S_OWN: begin
          if (fill_mode_q) begin
            eab_q   <= dst_q;
            rw_q    <= 1'b0;
            dout_q  <= fill_data_q;
            state_q <= S_WR_ADDR;
          end else begin
            eab_q   <= src_q;
            rw_q    <= 1'b1;
            state_q <= S_RD_ADDR;
          end
        end
        S_RD_ADDR: begin
          strb_n_q <= 1'b0;
          tmo_q    <= '0;
          state_q  <= S_RD_STB;
        end
        S_RD_STB: begin
          if (!bus.dtack_n) begin
            data_q   <= bus.din;
            strb_n_q <= 1'b1;
            state_q  <= S_RD_END;
          end else if (tmo_q == TMO_LAST) begin
            error_q   <= 1'b1;
            strb_n_q  <= 1'b1;
            bgack_n_q <= 1'b1;
            rw_q      <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_RELEASE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        S_RD_END: begin
          if (bus.dtack_n) begin
            eab_q   <= dst_q;
            rw_q    <= 1'b0;
            dout_q  <= data_q;
            state_q <= S_WR_ADDR;
          end
        end
        S_WR_ADDR: begin
          strb_n_q <= 1'b0;
          tmo_q    <= '0;
          state_q  <= S_WR_STB;
        end
        S_WR_STB: begin
          if (!bus.dtack_n) begin
            strb_n_q     <= 1'b1;
            src_q        <= src_q + 23'd1;
            dst_q        <= dst_q + 23'd1;
            words_done_q <= words_done_q + 16'd1;
            remain_q     <= remain_q - 16'd1;
            state_q      <= S_WR_END;
          end else if (tmo_q == TMO_LAST) begin
            error_q   <= 1'b1;
            strb_n_q  <= 1'b1;
            bgack_n_q <= 1'b1;
            rw_q      <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_RELEASE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        S_WR_END: begin
          if (bus.dtack_n) begin
            if (remain_q != 16'd0) begin
              if (fill_mode_q) begin
                eab_q   <= dst_q;
                rw_q    <= 1'b0;
                dout_q  <= fill_data_q;
                state_q <= S_WR_ADDR;
              end else begin
                eab_q   <= src_q;
                rw_q    <= 1'b1;
                state_q <= S_RD_ADDR;
              end
            end else begin
              bgack_n_q <= 1'b1;
              rw_q      <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign words_done_o = words_done_q;

  assign bus.br_n    = br_n_q;
  assign bus.bgack_n = bgack_n_q;
  assign bus.eab     = eab_q;
  assign bus.as_n    = strb_n_q;
  assign bus.uds_n   = strb_n_q;
  assign bus.lds_n   = strb_n_q;
  assign bus.rw      = rw_q;
  assign bus.dout    = dout_q;

endmodule

// File: tb/tb_m68k_bus_dma.sv
// tb/tb_m68k_bus_dma.sv - self-checking bench for m68k_bus_dma
module tb_m68k_bus_dma;

  typedef struct packed {
    logic        rw;
    logic [22:0] addr;
    logic [15:0] data;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [22:0] src_addr;
  logic [22:0] dst_addr;
  logic [15:0] word_count;
  logic        fill_mode;
  logic [15:0] fill_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_done;

  always #5 clk = ~clk;

  m68k_bus_dma_if bus();

  m68k_bus_dma #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start),
    .src_addr_i   (src_addr),
    .dst_addr_i   (dst_addr),
    .word_count_i (word_count),
    .fill_mode_i  (fill_mode),
    .fill_data_i  (fill_data),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .words_done_o (words_done),
    .bus          (bus.master)
  );

  // Responder memory and glue: DTACK asserts one cycle after AS and
  // releases as soon as AS negates; BG follows BR after gnt_delay cycles.
  logic [15:0] mem [logic [22:0]];
  logic        ack_q;
  logic        bg_q;
  logic [15:0] rdata_q;
  logic        resp_en;
  int unsigned gcnt;
  int unsigned gnt_delay;

  function automatic logic [15:0] mem_rd(input logic [22:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  assign bus.dtack_n = ~(ack_q & ~bus.as_n);
  assign bus.bg_n    = bg_q;
  assign bus.din     = rdata_q;

  always @(posedge clk) begin
    if (reset) begin
      ack_q   <= 1'b0;
      bg_q    <= 1'b1;
      gcnt    <= 0;
      rdata_q <= 16'h0000;
    end else begin
      ack_q   <= ~bus.as_n & resp_en;
      rdata_q <= mem_rd(bus.eab);
      if (bus.br_n) begin
        bg_q <= 1'b1;
        gcnt <= 0;
      end else if (gcnt >= gnt_delay) begin
        bg_q <= 1'b0;
      end else begin
        gcnt <= gcnt + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  bus_exp_t exp_q[$];

  int cyc = 0;
  int first_as_cyc, done_cyc, bgack_fall_cyc, br_fall_cyc;
  int ndone, viol, strb_rd, as_low, as_pre_grant, n_acked;
  logic        br_seen;
  logic        p_as_n = 1'b1;
  logic        p_rw = 1'b1;
  logic        p_br_n = 1'b1;
  logic        p_bgack_n = 1'b1;
  logic [22:0] p_eab = '0;
  logic [15:0] p_dout = '0;

  task automatic clear_stats();
    first_as_cyc = -1; done_cyc = -1; bgack_fall_cyc = -1; br_fall_cyc = -1;
    ndone = 0; viol = 0; strb_rd = 0; as_low = 0; as_pre_grant = 0; n_acked = 0;
    br_seen = 1'b0;
  endtask

  task automatic push_exp(input logic rw, input logic [22:0] a, input logic [15:0] d);
    bus_exp_t e;
    e.rw = rw; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // One clock: sample at the falling edge, run protocol monitors and the scoreboard.
  task automatic tick();
    bus_exp_t e;
    @(negedge clk);
    cyc++;
    if (!reset) begin
      if (!bus.as_n) begin
        as_low++;
        if (first_as_cyc < 0) first_as_cyc = cyc;
        if (bus.rw) strb_rd++;
        if (bus.bgack_n) as_pre_grant++;
        if (bus.eab !== p_eab || bus.rw !== p_rw || bus.dout !== p_dout) viol++;
      end else if (!p_as_n) begin
        if (bus.eab !== p_eab || bus.dout !== p_dout) viol++;
      end
      if (bus.uds_n !== bus.as_n || bus.lds_n !== bus.as_n) viol++;
    end
    if (!bus.as_n && !bus.dtack_n) begin
      n_acked++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("bus_rw", 32'(bus.rw), 32'(e.rw));
        check_eq("bus_addr", 32'(bus.eab), 32'(e.addr));
        if (!e.rw) check_eq("bus_wdata", 32'(bus.dout), 32'(e.data));
      end
      if (!bus.rw) mem[bus.eab] = bus.dout;
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
    if (!bus.br_n) br_seen = 1'b1;
    if (!bus.br_n && p_br_n) br_fall_cyc = cyc;
    if (!bus.bgack_n && p_bgack_n) bgack_fall_cyc = cyc;
    p_as_n = bus.as_n; p_rw = bus.rw; p_eab = bus.eab; p_dout = bus.dout;
    p_br_n = bus.br_n; p_bgack_n = bus.bgack_n;
  endtask

  task automatic issue(input logic [22:0] s, input logic [22:0] d, input logic [15:0] n,
                       input logic fm, input logic [15:0] fd);
    src_addr = s; dst_addr = d; word_count = n; fill_mode = fm; fill_data = fd;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && ndone == 0; i++) tick();
    check_eq("done_seen", 32'(ndone), 32'd1);
  endtask

  initial begin
    logic found;
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
    fill_mode = 1'b0; fill_data = '0; resp_en = 1'b1; gnt_delay = 0;
    clear_stats();
    repeat (3) tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_words", 32'(words_done), 32'd0);
    check_eq("rst_pins", 32'({bus.br_n, bus.bgack_n, bus.as_n, bus.uds_n, bus.lds_n, bus.rw}), 32'h3F);
    check_eq("rst_eab", 32'(bus.eab), 32'd0);
    check_eq("rst_dout", 32'(bus.dout), 32'd0);
    reset = 1'b0;
    tick();

    // Copy four words.
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      mem[23'h080000 + 23'(i)] = 16'(16'h1111 * (i + 1));
      push_exp(1'b1, 23'h080000 + 23'(i), 16'h0000);
      push_exp(1'b0, 23'h080100 + 23'(i), 16'(16'h1111 * (i + 1)));
    end
    issue(23'h080000, 23'h080100, 16'd4, 1'b0, 16'h0000);
    wait_done(200);
    check_eq("copy_words", 32'(words_done), 32'd4);
    check_eq("copy_error", 32'(error), 32'd0);
    check_eq("copy_cycles", 32'(done_cyc - first_as_cyc), 32'd31);
    check_eq("copy_acked", 32'(n_acked), 32'd8);
    for (int i = 0; i < 4; i++)
      check_eq("copy_mem", 32'(mem_rd(23'h080100 + 23'(i))), 32'(16'h1111 * (i + 1)));
    tick();
    check_eq("copy_done_pulse", 32'({done, busy, bus.bgack_n}), 32'b001);
    check_eq("copy_ndone", 32'(ndone), 32'd1);
    check_eq("copy_protocol", 32'(viol), 32'd0);

    // Fill three words.
    clear_stats();
    for (int i = 0; i < 3; i++) push_exp(1'b0, 23'h080200 + 23'(i), 16'hA5A5);
    issue(23'h000123, 23'h080200, 16'd3, 1'b1, 16'hA5A5);
    wait_done(200);
    check_eq("fill_words", 32'(words_done), 32'd3);
    check_eq("fill_no_reads", 32'(strb_rd), 32'd0);
    check_eq("fill_cycles", 32'(done_cyc - first_as_cyc), 32'd11);
    check_eq("fill_acked", 32'(n_acked), 32'd3);
    for (int i = 0; i < 3; i++)
      check_eq("fill_mem", 32'(mem_rd(23'h080200 + 23'(i))), 32'hA5A5);
    check_eq("fill_protocol", 32'(viol), 32'd0);
    tick();

    // Zero count.
    clear_stats();
    issue(23'h080000, 23'h080800, 16'd0, 1'b0, 16'h0000);
    check_eq("zero_done", 32'(done), 32'd1);
    tick();
    check_eq("zero_done_end", 32'(done), 32'd0);
    tick();
    check_eq("zero_ndone", 32'(ndone), 32'd1);
    check_eq("zero_no_br", 32'(br_seen), 32'd0);
    check_eq("zero_busy", 32'(busy), 32'd0);

    // Start while busy is ignored; inputs changing after acceptance are ignored.
    clear_stats();
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b1, 23'h080000 + 23'(i), 16'h0000);
      push_exp(1'b0, 23'h080300 + 23'(i), 16'(16'h1111 * (i + 1)));
    end
    issue(23'h080000, 23'h080300, 16'd2, 1'b0, 16'h0000);
    repeat (10) tick();
    check_eq("busy_mid", 32'(busy), 32'd1);
    issue(23'h070000, 23'h070100, 16'd5, 1'b1, 16'h5A5A);
    src_addr = 23'h012345; dst_addr = 23'h054321; word_count = 16'd9; fill_mode = 1'b1;
    wait_done(200);
    check_eq("busy_words", 32'(words_done), 32'd2);
    check_eq("busy_acked", 32'(n_acked), 32'd4);
    check_eq("busy_exp_left", 32'(exp_q.size()), 32'd0);
    tick();

    // DTACK never arrives.
    clear_stats();
    resp_en = 1'b0;
    issue(23'h080000, 23'h080500, 16'd3, 1'b0, 16'h0000);
    wait_done(200);
    check_eq("tmo_error", 32'(error), 32'd1);
    check_eq("tmo_words", 32'(words_done), 32'd0);
    check_eq("tmo_strobe_cycles", 32'(as_low), 32'd8);
    check_eq("tmo_acked", 32'(n_acked), 32'd0);
    check_eq("tmo_released", 32'({bus.bgack_n, bus.as_n}), 32'b11);
    tick();
    check_eq("tmo_idle", 32'({busy, done, bus.br_n}), 32'b001);
    resp_en = 1'b1;
    clear_stats();
    push_exp(1'b1, 23'h080000, 16'h0000);
    push_exp(1'b0, 23'h080600, 16'h1111);
    issue(23'h080000, 23'h080600, 16'd1, 1'b0, 16'h0000);
    check_eq("tmo_error_clear", 32'(error), 32'd0);
    wait_done(200);
    check_eq("tmo_next_words", 32'(words_done), 32'd1);
    tick();

    // Address wrap with a delayed grant.
    clear_stats();
    gnt_delay = 10;
    mem[23'h7FFFFF] = 16'hBEEF;
    mem[23'h000000] = 16'hCAFE;
    push_exp(1'b1, 23'h7FFFFF, 16'h0000);
    push_exp(1'b0, 23'h080400, 16'hBEEF);
    push_exp(1'b1, 23'h000000, 16'h0000);
    push_exp(1'b0, 23'h080401, 16'hCAFE);
    issue(23'h7FFFFF, 23'h080400, 16'd2, 1'b0, 16'h0000);
    wait_done(300);
    check_eq("wrap_pre_grant_as", 32'(as_pre_grant), 32'd0);
    check_eq("wrap_req_to_as", 32'(first_as_cyc - br_fall_cyc), 32'd14);
    check_eq("wrap_own_to_as", 32'(first_as_cyc - bgack_fall_cyc), 32'd2);
    check_eq("wrap_acked", 32'(n_acked), 32'd4);
    check_eq("wrap_words", 32'(words_done), 32'd2);
    gnt_delay = 0;
    tick();

    // Reset in the middle of a write strobe.
    clear_stats();
    push_exp(1'b1, 23'h080000, 16'h0000);
    issue(23'h080000, 23'h080700, 16'd3, 1'b0, 16'h0000);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (!bus.as_n && !bus.rw) found = 1'b1;
    end
    check_eq("rst_mid_reached_wr", 32'(found), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("rst_mid_pins", 32'({bus.as_n, bus.uds_n, bus.lds_n, bus.br_n, bus.bgack_n, bus.rw}), 32'h3F);
    check_eq("rst_mid_busy_done", 32'({busy, done}), 32'd0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check_eq("rst_mid_no_done", 32'(ndone), 32'd0);
    check_eq("rst_mid_idle", 32'({busy, bus.br_n}), 32'b01);
    exp_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m68k_bus_dma.md
# m68k_bus_dma

Word-copy/fill DMA engine that acts as a 68000-style bus initiator. It is the master side of the AS/UDS/LDS/DTACK handshake that the system bus glue answers as responder. It takes bus ownership through the BR/BG/BGACK arbitration pins and moves up to 65535 16-bit words between word addresses, or fills a range with a constant. It sits beside the fx68k on the shared address/data bus and is programmed by a small command port.

## Interface
Parameters:
- TIMEOUT, 255: clk cycles allowed from AS assertion to DTACK before the transfer aborts with error. Legal range 1..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle command strobe; sampled only in IDLE
- src_addr  in  23  source word address (byte address = {src_addr,0})
- dst_addr  in  23  destination word address
- word_count  in  16  number of words to transfer; 0 means no transfer
- fill_mode  in  1  1 = write fill_data to every destination and skip reads
- fill_data  in  16  fill value
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at the end of every accepted command
- error  out  1  sticky timeout flag; cleared by the next accepted start
- words_done  out  16  words written so far; cleared by an accepted start
- br_n  out  1  bus request
- bg_n  in  1  bus grant
- bgack_n  out  1  bus grant acknowledge; low while this block owns the bus
- eab  out  23  word address
- as_n, uds_n, lds_n  out  1 each  address and data strobes; both data strobes are always driven together
- rw  out  1  1 = read, 0 = write
- dout  out  16  write data
- din  in  16  read data
- dtack_n  in  1  data acknowledge from the responder

## Operation
- Reset values: busy=0, done=0, error=0, words_done=0, br_n=1, bgack_n=1, as_n=uds_n=lds_n=1, rw=1, eab=0, dout=0.
- States:
  - IDLE: on start with word_count=0, done pulses on the next cycle and no bus activity occurs. On start with word_count>0, latch all command inputs, then go to REQ.
  - REQ: br_n=0; wait for bg_n=0 and dtack_n=1.
  - OWN: bgack_n=0, br_n=1; one cycle; then go to RD_ADDR, or to WR_ADDR if fill_mode.
  - RD_ADDR: eab=src, rw=1; then go to RD_STB.
  - RD_STB: as_n=uds_n=lds_n=0; wait for dtack_n=0, then latch din into the data register and go to RD_END.
  - RD_END: negate the strobes; wait for dtack_n=1, then go to WR_ADDR.
  - WR_ADDR: eab=dst, rw=0, dout=data register (or fill_data); then go to WR_STB.
  - WR_STB: strobes low; wait for dtack_n=0.
  - WR_END: negate the strobes; increment src, dst and words_done; decrement the remaining count; wait for dtack_n=1. If remaining>0, go to RD_ADDR or WR_ADDR; otherwise go to RELEASE.
  - RELEASE: bgack_n=1, rw=1; done pulse; busy=0; go to IDLE.
- Timeout: a counter clears on strobe assertion and increments in every *_STB cycle. When it reaches TIMEOUT without DTACK, set error=1, negate the strobes, and go to RELEASE; the remaining words are abandoned.
- Address arithmetic: src and dst wrap modulo 2^23. words_done counts only completed writes.
- start while busy is ignored and has no side effects on any register.
- The latched command is immune to input changes after acceptance.
- Reset mid-operation returns all outputs to their reset values on the same edge. The bus is released immediately and no done pulse is generated.

## Timing
- All outputs are registered.
- eab, rw and dout are stable at least one cycle before as_n falls, and remain stable until the cycle after the strobes negate.
- dtack_n is sampled on clk; din is captured on the edge where dtack_n=0 is first seen in RD_STB.
- With zero-wait responses (DTACK registered one cycle after AS), the copy cost per word is fixed at 2 cycles per bus cycle plus handshake:
  - read: 4 cycles (addr, stb, stb+dtack, end)
  - write: 4 cycles
  - one copied word = 8 cycles; one fill word = 4 cycles.
- Latency from grant to the first as_n low is 2 cycles (OWN, RD_ADDR).
- done asserts exactly 1 cycle, in the RELEASE cycle. busy falls in the cycle after done.
- A new bus cycle never starts while dtack_n is still low from the previous cycle.

## Test plan
- Copy: src=0x080000, dst=0x080100, count=4, responder with 1-cycle DTACK, source words 0x1111..0x4444 → the destination holds the same four words, words_done=4, one done pulse, error=0, bgack_n high again after done.
- Fill: fill_mode=1, fill_data=0xA5A5, count=3 → three writes only (rw never 1 while a strobe is low), 4 cycles per word, dst..dst+2 = 0xA5A5.
- Zero count and busy start: count=0 → done on the next cycle, br_n stays 1. A second start issued mid-transfer → ignored; the first transfer completes unchanged.
- Timeout: TIMEOUT=8, responder never asserts DTACK → strobes negate after 8 stalled cycles, error=1, words_done=0, done pulses, bus released. The next start clears error.
- Wrap and arbitration: src=0x7FFFFF, count=2, bg_n delayed 10 cycles → as_n stays high until the grant. The second read address is 0x000000.
- Reset asserted during WR_STB → on the next edge all strobes, br_n and bgack_n are 1, busy=0, and no done pulse occurs.
